tx_burst_packer: RTL and testbench

Transmit-side feeder sitting directly upstream of the network stack's payload input (`axiiv`/`axiid`). Accepts a free-running stream of DATA_SIZE-bit samples, buffers them in an internal FIFO, and emits them as contiguous fixed-length bursts. The stack frames and sends a UDP packet on the falling edge of its valid input, so each burst becomes exactly one packet. A hold-off period after each burst lets the stack finish transmitting before the next burst is presented.

---
 rtl/tx_burst_packer.sv | 171 +++++++++++++++++
 tb/tb_tx_burst_packer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_packer.sv
// FIFO-backed burst packer feeding the UDP stack: buffers a sample stream and replays it as
// gapless BURST_LEN-word bursts separated by a hold-off. PACKER_TIMEOUT_EN enables idle flush of partial bursts.
module tx_burst_packer #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 32,
    parameter int HOLDOFF   = 2048,
    parameter int TIMEOUT   = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_SIZE-1:0]   in_data,
    output logic                   in_ready,
    output logic                   axiov,
    output logic [DATA_SIZE-1:0]   axiod,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [15:0]            burst_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    generate
        if (BURST_LEN < 1 || BURST_LEN > DEPTH || HOLDOFF < 1 || TIMEOUT < 1) begin : g_param_check
            $error("tx_burst_packer: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {FILL, SEND, HOLD} state_t;

    state_t                 state_reg;
    logic [DATA_SIZE-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [FW-1:0]          count_reg;
    logic [FW-1:0]          count_next;
    logic [FW-1:0]          burst_len_q;
    logic [FW-1:0]          send_cnt_reg;
    logic [HW-1:0]          hold_cnt_reg;
    logic                   axiov_reg;
    logic [DATA_SIZE-1:0]   axiod_reg;
    logic                   overflow_reg;
    logic [15:0]            drop_count_reg;
    logic [15:0]            burst_count_reg;
    logic                   push;
    logic                   pop;
    logic                   drop;

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]          idle_cnt_reg;
`endif

    // in_ready is forced low while reset is held so nothing is pushed into a FIFO being cleared
    assign in_ready    = rst_n & (count_reg != FW'(DEPTH));
    assign push        = in_valid & in_ready;
    assign drop        = in_valid & ~in_ready;
    assign pop         = (state_reg == SEND);

    assign axiov       = axiov_reg;
    assign axiod       = axiod_reg;
    assign fill_level  = count_reg;
    assign overflow    = overflow_reg;
    assign drop_count  = drop_count_reg;
    assign burst_count = burst_count_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + FW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            overflow_reg <= drop;
            if (drop && drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    // FILL looks at count_next so the burst starts the cycle after the push that completes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FILL;
            burst_len_q     <= '0;
            send_cnt_reg    <= '0;
            hold_cnt_reg    <= '0;
            axiov_reg       <= 1'b0;
            axiod_reg       <= '0;
            burst_count_reg <= '0;
`ifdef PACKER_TIMEOUT_EN
            idle_cnt_reg    <= '0;
`endif
        end else begin
            axiov_reg <= pop;
            axiod_reg <= pop ? mem[rd_ptr_reg] : '0;
            case (state_reg)
                FILL: begin
                    if (count_next >= FW'(BURST_LEN)) begin
                        burst_len_q  <= FW'(BURST_LEN);
                        send_cnt_reg <= '0;
                        state_reg    <= SEND;
`ifdef PACKER_TIMEOUT_EN
                        idle_cnt_reg <= '0;
                    end else if (push || count_reg == '0) begin
                        idle_cnt_reg <= '0;
                    end else if (idle_cnt_reg == TW'(TIMEOUT - 1)) begin
                        burst_len_q  <= count_reg;
                        send_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                        state_reg    <= SEND;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + TW'(1);
`endif
                    end
                end
                SEND: begin
                    if (send_cnt_reg == burst_len_q - FW'(1)) begin
                        state_reg       <= HOLD;
                        hold_cnt_reg    <= HW'(HOLDOFF - 1);
                        burst_count_reg <= burst_count_reg + 16'd1;
                    end else begin
                        send_cnt_reg <= send_cnt_reg + FW'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_reg <= FILL;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_burst_packer.sv
// Randomized self-checking bench for tx_burst_packer: queue-based expected stream, burst
// timing from rise/fall cycle logs. Timeout scenario follows PACKER_TIMEOUT_EN.
module tb_tx_burst_packer;

    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int BL    = 32;
    localparam int HOLD  = 16;
    localparam int TO    = 50;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [DW-1:0]          in_data = '0;
    logic                   in_ready;
    logic                   axiov;
    logic [DW-1:0]          axiod;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow;
    logic [15:0]            drop_count;
    logic [15:0]            burst_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_push_cyc = 0;
    int n_blocked = 0;
    int rx_mark = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];
    int rise_q[$];
    int fall_q[$];
    logic run_active = 1'b0;
    int idle_bad = 0;
    int ovf_pulses = 0;

    tx_burst_packer #(
        .DATA_SIZE(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .HOLDOFF(HOLD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .axiov(axiov), .axiod(axiod), .fill_level(fill_level),
        .overflow(overflow), .drop_count(drop_count), .burst_count(burst_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs every word shown on axiov plus the cycle of each rise and fall.
    always @(negedge clk) begin
        if (axiov === 1'b1) begin
            if (!run_active) rise_q.push_back(cyc);
            run_active <= 1'b1;
            rx_q.push_back(axiod);
        end else begin
            if (run_active) begin
                fall_q.push_back(cyc);
                $display("burst %0d: len=%0d at cycle %0d", fall_q.size(), cyc - rise_q[rise_q.size()-1], cyc);
            end
            run_active <= 1'b0;
            if (axiod !== '0) idle_bad <= idle_bad + 1;
        end
        if (overflow === 1'b1) ovf_pulses <= ovf_pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready === 1'b1) exp_q.push_back(d);
        else n_blocked++;
        last_push_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic resync();
        exp_q.delete();
        rx_mark = rx_q.size();
        n_blocked = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        resync();
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        int k = 0;
        while (fall_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        to_neg();
        ok = (fall_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL reset_axiov: got %b want 0", axiov); end
        checks++; if (axiod !== '0) begin errors++; $display("FAIL reset_axiod: got %h want 0", axiod); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        checks++; if (burst_count !== 16'd0) begin errors++; $display("FAIL reset_bursts: got %0d want 0", burst_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        resync();
    endtask

    task automatic test_full_burst();
        int r0 = rise_q.size();
        int bad0 = idle_bad;
        bit ok;
        for (int i = 0; i < BL; i++) push_word(DW'($urandom));
        checks++; if (exp_q.size() != BL) begin errors++; $display("FAIL full_accept: accepted %0d want %0d", exp_q.size(), BL); end
        wait_falls(r0 + 1, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL full_wait: no burst completed, falls=%0d", fall_q.size());
        end else begin
            checks++; if (rise_q[r0] != last_push_cyc + 2) begin errors++; $display("FAIL full_latency: rise at %0d want %0d", rise_q[r0], last_push_cyc + 2); end
            checks++; if (fall_q[r0] - rise_q[r0] != BL) begin errors++; $display("FAIL full_len: got %0d want %0d", fall_q[r0] - rise_q[r0], BL); end
        end
        for (int i = 0; i < BL; i++) begin
            checks++;
            if (rx_mark + i >= rx_q.size() || rx_q[rx_mark + i] !== exp_q[i]) begin
                errors++; $display("FAIL full_data[%0d]: got %h want %h", i, (rx_mark + i < rx_q.size()) ? rx_q[rx_mark + i] : 'x, exp_q[i]);
            end
        end
        checks++; if (burst_count !== 16'd1) begin errors++; $display("FAIL full_bursts: got %0d want 1", burst_count); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL full_fill: got %0d want 0", fill_level); end
        checks++; if (idle_bad != bad0) begin errors++; $display("FAIL full_idle_data: %0d nonzero idle words want 0", idle_bad - bad0); end
    endtask

    task automatic test_continuous();
        int r0;
        bit ok;
        do_reset();
        r0 = rise_q.size();
        for (int i = 0; i < 100; i++) begin
            push_word(DW'($urandom));
            repeat (3) tick();
        end
        wait_falls(r0 + 3, 400, ok);
        repeat (5) tick();
        to_neg();
        checks++; if (!ok || rise_q.size() - r0 != 3) begin errors++; $display("FAIL cont_bursts_seen: got %0d want 3", rise_q.size() - r0); end
        if (ok) begin
            for (int b = 0; b < 3; b++) begin
                checks++; if (fall_q[r0+b] - rise_q[r0+b] != BL) begin errors++; $display("FAIL cont_len[%0d]: got %0d want %0d", b, fall_q[r0+b] - rise_q[r0+b], BL); end
            end
            for (int b = 1; b < 3; b++) begin
                checks++; if (rise_q[r0+b] - fall_q[r0+b-1] < HOLD + 1) begin errors++; $display("FAIL cont_gap[%0d]: got %0d want >= %0d", b, rise_q[r0+b] - fall_q[r0+b-1], HOLD + 1); end
            end
        end
        checks++; if (rx_q.size() - rx_mark != 3 * BL) begin errors++; $display("FAIL cont_words: got %0d want %0d", rx_q.size() - rx_mark, 3 * BL); end
        for (int i = 0; i < 3 * BL && rx_mark + i < rx_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
        checks++; if (fill_level !== 7'd4) begin errors++; $display("FAIL cont_fill: got %0d want 4", fill_level); end
        checks++; if (burst_count !== 16'd3) begin errors++; $display("FAIL cont_bursts: got %0d want 3", burst_count); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int f0;
        do_reset();
        f0 = fall_q.size();
        for (int j = 0; j < 2 * BL; j++) begin
            push_word(DW'($urandom));
            if (j >= BL - 1 && j < 2 * BL - 1) begin
                checks++; if (fill_level !== 7'(BL)) begin errors++; $display("FAIL simul_fill[%0d]: got %0d want %0d", j, fill_level, BL); end
            end
        end
        wait_falls(f0 + 2, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_wait: falls=%0d want %0d", fall_q.size() - f0, 2); end
        checks++; if (rx_q.size() - rx_mark != 2 * BL) begin errors++; $display("FAIL simul_words: got %0d want %0d", rx_q.size() - rx_mark, 2 * BL); end
        for (int i = 0; i < 2 * BL && rx_mark + i < rx_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL simul_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
        checks++; if (burst_count !== 16'd2) begin errors++; $display("FAIL simul_bursts: got %0d want 2", burst_count); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL simul_end_fill: got %0d want 0", fill_level); end
    endtask

    task automatic test_overflow();
        int ovf0;
        int n_rx;
        do_reset();
        ovf0 = ovf_pulses;
        for (int i = 0; i < 200; i++) begin
            checks++;
            if (fill_level > DEPTH || (in_ready === 1'b0) != (fill_level == 7'(DEPTH))) begin
                errors++; $display("FAIL ovf_ready[%0d]: in_ready=%b fill=%0d", i, in_ready, fill_level);
            end
            push_word(DW'($urandom));
        end
        to_neg();
        checks++; if (n_blocked == 0) begin errors++; $display("FAIL ovf_any: got 0 blocked pushes want >0"); end
        checks++; if (drop_count !== 16'(n_blocked)) begin errors++; $display("FAIL ovf_drop_count: got %0d want %0d", drop_count, n_blocked); end
        checks++; if (ovf_pulses - ovf0 != n_blocked) begin errors++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_pulses - ovf0, n_blocked); end
        repeat (300) tick();
        to_neg();
        n_rx = rx_q.size() - rx_mark;
        checks++; if (n_rx + int'(fill_level) != exp_q.size()) begin errors++; $display("FAIL ovf_conserve: rx=%0d fill=%0d want total %0d", n_rx, fill_level, exp_q.size()); end
        for (int i = 0; i < n_rx && i < exp_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int base = rx_q.size();
        int k = 0;
        int f0;
        bit ok;
        for (int i = 0; i < BL; i++) push_word(DW'($urandom));
        while (rx_q.size() < base + 10 && k < 200) begin
            to_neg();
            k++;
        end
        checks++; if (rx_q.size() < base + 10) begin errors++; $display("FAIL rst_mid_wait: got %0d words want 10", rx_q.size() - base); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL rst_mid_axiov: got %b want 0", axiov); end
        checks++; if (burst_count !== 16'd0) begin errors++; $display("FAIL rst_mid_bursts: got %0d want 0", burst_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_mid_drop: got %0d want 0", drop_count); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL rst_mid_fill: got %0d want 0", fill_level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_in_ready: got %b want 1", in_ready); end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL rst_rel_fill: got %0d want 0", fill_level); end
        resync();
        f0 = fall_q.size();
        for (int i = 0; i < BL; i++) push_word(DW'($urandom));
        wait_falls(f0 + 1, 200, ok);
        checks++; if (!ok || rx_q.size() - rx_mark != BL) begin errors++; $display("FAIL rst_next_words: got %0d want %0d", rx_q.size() - rx_mark, BL); end
        for (int i = 0; i < BL && rx_mark + i < rx_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL rst_next_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
        checks++; if (burst_count !== 16'd1) begin errors++; $display("FAIL rst_next_bursts: got %0d want 1", burst_count); end
    endtask

    task automatic test_timeout();
        int r0;
        bit ok;
        do_reset();
        r0 = rise_q.size();
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
`ifdef PACKER_TIMEOUT_EN
        wait_falls(r0 + 1, TO + 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_wait: no short burst, falls=%0d", fall_q.size() - r0); end
        if (ok) begin
            checks++; if (rise_q[r0] < last_push_cyc + TO || rise_q[r0] > last_push_cyc + TO + 3) begin errors++; $display("FAIL to_when: rise %0d cycles after last push want %0d..%0d", rise_q[r0] - last_push_cyc, TO, TO + 3); end
            checks++; if (fall_q[r0] - rise_q[r0] != 5) begin errors++; $display("FAIL to_len: got %0d want 5", fall_q[r0] - rise_q[r0]); end
        end
        for (int i = 0; i < 5 && rx_mark + i < rx_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL to_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
        checks++; if (fill_level !== '0) begin errors++; $display("FAIL to_fill: got %0d want 0", fill_level); end
        checks++; if (burst_count !== 16'd1) begin errors++; $display("FAIL to_bursts: got %0d want 1", burst_count); end
`else
        repeat (4 * TO) tick();
        to_neg();
        checks++; if (rise_q.size() != r0) begin errors++; $display("FAIL nto_burst: got %0d bursts want 0", rise_q.size() - r0); end
        checks++; if (fill_level !== 7'd5) begin errors++; $display("FAIL nto_fill: got %0d want 5", fill_level); end
        for (int i = 5; i < BL; i++) push_word(DW'($urandom));
        wait_falls(r0 + 1, 200, ok);
        checks++; if (!ok || fall_q[r0] - rise_q[r0] != BL) begin errors++; $display("FAIL nto_full_len: burst incomplete or wrong length"); end
        for (int i = 0; i < BL && rx_mark + i < rx_q.size(); i++) begin
            checks++; if (rx_q[rx_mark + i] !== exp_q[i]) begin errors++; $display("FAIL nto_data[%0d]: got %h want %h", i, rx_q[rx_mark + i], exp_q[i]); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_continuous();
        test_simultaneous();
        test_overflow();
        test_reset_mid_burst();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
